// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: word width, the NOP encoding and the IF stage state encoding.
package mips_pkg;

   localparam int unsigned WORD_W = 32;

   // sll $0,$0,0
   localparam logic [WORD_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

   // StExc is only reachable when IF_MISALIGN_CHECK_EN is defined
   typedef enum logic [1:0] {
      StFetch = 2'b00,
      StHold  = 2'b01,
      StDrop  = 2'b10,
      StExc   = 2'b11
   } if_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {instr, pc4} parking register used while decode is stalled.
module fetch_hold_buf
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [WORD_W-1:0] instr_in,
   input  logic [WORD_W-1:0] pc4_in,
   output logic              valid,
   output logic [WORD_W-1:0] instr,
   output logic [WORD_W-1:0] pc4
);

   logic              valid_q, valid_d;
   logic [WORD_W-1:0] instr_q, instr_d;
   logic [WORD_W-1:0] pc4_q, pc4_d;

   // Next-state: clear wins over load so a flush always empties the entry
   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         instr_d = instr_in;
         pc4_d   = pc4_in;
      end
   end

   // Storage with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc4_q   <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
      end
   end

   assign valid = valid_q;
   assign instr = instr_q;
   assign pc4   = pc4_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// MIPS IF stage: PC, req/ready instruction fetch, IF/ID register, stall hold buffer and
// redirect flush. Optional macro IF_MISALIGN_CHECK_EN traps misaligned redirect targets.
module instr_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              STALL,
   input  logic              REDIRECT,
   input  logic [WORD_W-1:0] REDIRECT_PC,
   output logic              IMEM_REQ,
   output logic [WORD_W-1:0] IMEM_ADDR,
   input  logic              IMEM_READY,
   input  logic [WORD_W-1:0] IMEM_RDATA,
   output logic [WORD_W-1:0] IFID_INSTR,
   output logic [WORD_W-1:0] IFID_PC4,
   output logic              IFID_VALID,
   output logic              FETCH_EXC
);

   if_state_e         state_q, state_d;
   logic [WORD_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] drop_addr_q, drop_addr_d;
   logic [WORD_W-1:0] ifid_instr_q, ifid_instr_d;
   logic [WORD_W-1:0] ifid_pc4_q, ifid_pc4_d;
   logic              ifid_valid_q, ifid_valid_d;
   logic              exc_q, exc_d;

   logic              buf_load, buf_clear, buf_valid;
   logic [WORD_W-1:0] buf_instr, buf_pc4;
   logic [WORD_W-1:0] pc_plus4;

   // Wraps modulo 2^32 by width truncation
   assign pc_plus4 = pc_q + 32'd4;

   fetch_hold_buf u_hold_buf (
      .clk      (CLK),
      .rst      (RST),
      .load     (buf_load),
      .clear    (buf_clear),
      .instr_in (IMEM_RDATA),
      .pc4_in   (pc_plus4),
      .valid    (buf_valid),
      .instr    (buf_instr),
      .pc4      (buf_pc4)
   );

   // Next-state for PC, FSM, IF/ID and exception flag; redirect beats stall beats progress
   always_comb begin
      pc_d         = pc_q;
      state_d      = state_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      exc_d        = exc_q;
      buf_load     = 1'b0;
      buf_clear    = 1'b0;
      // Remember the address of a request we may have to abandon
      drop_addr_d  = (state_q == StFetch) ? pc_q : drop_addr_q;

      if (REDIRECT) begin
         ifid_instr_d = NOP_INSTR;
         ifid_valid_d = 1'b0;
         buf_clear    = 1'b1;
`ifdef IF_MISALIGN_CHECK_EN
         if (REDIRECT_PC[1:0] != 2'b00) begin
            exc_d = 1'b1;
         end else begin
            exc_d = 1'b0;
            pc_d  = REDIRECT_PC;
         end
`else
         exc_d = 1'b0;
         pc_d  = REDIRECT_PC & ~32'd3;
`endif
         // An outstanding request must still complete its handshake
         unique case (state_q)
            StFetch: state_d = IMEM_READY ? StFetch : StDrop;
            StDrop:  state_d = IMEM_READY ? StFetch : StDrop;
            default: state_d = StFetch;
         endcase
         if (exc_d && (state_d == StFetch)) begin
            state_d = StExc;
         end
      end else begin
         unique case (state_q)
            StFetch: begin
               if (IMEM_READY) begin
                  pc_d = pc_plus4;
                  if (STALL) begin
                     buf_load = 1'b1;
                     state_d  = StHold;
                  end else begin
                     ifid_instr_d = IMEM_RDATA;
                     ifid_pc4_d   = pc_plus4;
                     ifid_valid_d = 1'b1;
                  end
               end else if (!STALL) begin
                  ifid_valid_d = 1'b0;
               end
            end
            StHold: begin
               if (!STALL) begin
                  ifid_instr_d = buf_instr;
                  ifid_pc4_d   = buf_pc4;
                  ifid_valid_d = buf_valid;
                  buf_clear    = 1'b1;
                  state_d      = StFetch;
               end
            end
            StDrop: begin
               if (IMEM_READY) begin
                  state_d = exc_q ? StExc : StFetch;
               end
            end
            StExc: begin
               state_d = StExc;
            end
         endcase
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= StFetch;
         pc_q         <= RESET_PC;
         drop_addr_q  <= RESET_PC;
         ifid_instr_q <= NOP_INSTR;
         ifid_pc4_q   <= '0;
         ifid_valid_q <= 1'b0;
         exc_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drop_addr_q  <= drop_addr_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
         exc_q        <= exc_d;
      end
   end

   assign IMEM_REQ   = (state_q == StFetch) || (state_q == StDrop);
   assign IMEM_ADDR  = (state_q == StDrop) ? drop_addr_q : pc_q;
   assign IFID_INSTR = ifid_instr_q;
   assign IFID_PC4   = ifid_pc4_q;
   assign IFID_VALID = ifid_valid_q;
   assign FETCH_EXC  = exc_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage; memory returns RDATA = address.
module tb_instr_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic        fetch_exc;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign imem_rdata = imem_addr;

   instr_fetch_stage dut (
      .CLK         (clk),
      .RST         (rst),
      .STALL       (stall),
      .REDIRECT    (redirect),
      .REDIRECT_PC (redirect_pc),
      .IMEM_REQ    (imem_req),
      .IMEM_ADDR   (imem_addr),
      .IMEM_READY  (imem_ready),
      .IMEM_RDATA  (imem_rdata),
      .IFID_INSTR  (ifid_instr),
      .IFID_PC4    (ifid_pc4),
      .IFID_VALID  (ifid_valid),
      .FETCH_EXC   (fetch_exc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 ns after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst         = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
      chk("rst_instr", ifid_instr, 32'h0);
      chk("rst_pc4", ifid_pc4, 32'h0);
      chk("rst_exc", {31'b0, fetch_exc}, 32'd0);
      chk("rst_req", {31'b0, imem_req}, 32'd1);
      chk("rst_addr", imem_addr, 32'h0);

      // 1: streaming fetch, one instruction per cycle
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("seq_pc4", ifid_pc4, 32'(4 * i));
         chk("seq_instr", ifid_instr, 32'(4 * (i - 1)));
         chk("seq_valid", {31'b0, ifid_valid}, 32'd1);
      end

      // 2: memory wait at 0x10
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("wait_addr", imem_addr, 32'h10);
         chk("wait_req", {31'b0, imem_req}, 32'd1);
         chk("wait_valid", {31'b0, ifid_valid}, 32'd0);
      end
      imem_ready = 1'b1;
      step();
      chk("wait_instr", ifid_instr, 32'h10);
      chk("wait_pc4", ifid_pc4, 32'h14);
      chk("wait_valid_after", {31'b0, ifid_valid}, 32'd1);

      // 3: stall while word@0x20 returns
      repeat (3) step();
      chk("pre_stall_addr", imem_addr, 32'h20);
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("hold_req", {31'b0, imem_req}, 32'd0);
         chk("hold_instr", ifid_instr, 32'h1C);
         chk("hold_pc4", ifid_pc4, 32'h20);
         chk("hold_valid", {31'b0, ifid_valid}, 32'd1);
      end
      stall = 1'b0;
      step();
      chk("release_pc4", ifid_pc4, 32'h24);
      chk("release_instr", ifid_instr, 32'h20);
      chk("release_addr", imem_addr, 32'h24);
      chk("release_req", {31'b0, imem_req}, 32'd1);

      // 4a: redirect to 0x40 with data returning
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      step();
      redirect = 1'b0;
      chk("redir_valid", {31'b0, ifid_valid}, 32'd0);
      chk("redir_instr", ifid_instr, 32'h0);
      chk("redir_addr", imem_addr, 32'h40);

      // 4b: redirect to 0x100 while 0x40 is outstanding
      imem_ready  = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      chk("drop_addr0", imem_addr, 32'h40);
      chk("drop_req0", {31'b0, imem_req}, 32'd1);
      chk("drop_valid0", {31'b0, ifid_valid}, 32'd0);
      step();
      chk("drop_addr1", imem_addr, 32'h40);
      chk("drop_valid1", {31'b0, ifid_valid}, 32'd0);
      imem_ready = 1'b1;
      step();
      chk("drop_valid2", {31'b0, ifid_valid}, 32'd0);
      chk("drop_newaddr", imem_addr, 32'h100);
      chk("drop_newreq", {31'b0, imem_req}, 32'd1);
      step();
      chk("post_drop_instr", ifid_instr, 32'h100);
      chk("post_drop_pc4", ifid_pc4, 32'h104);
      chk("post_drop_valid", {31'b0, ifid_valid}, 32'd1);

      // 5: redirect and stall together
      redirect    = 1'b1;
      stall       = 1'b1;
      redirect_pc = 32'h300;
      step();
      redirect = 1'b0;
      stall    = 1'b0;
      chk("rs_valid", {31'b0, ifid_valid}, 32'd0);
      chk("rs_instr", ifid_instr, 32'h0);
      chk("rs_addr", imem_addr, 32'h300);
      step();
      chk("rs_next_instr", ifid_instr, 32'h300);
      chk("rs_next_pc4", ifid_pc4, 32'h304);

      // PC+4 wraps at the top of the address space
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      step();
      chk("wrap_pc4", ifid_pc4, 32'h0);
      chk("wrap_instr", ifid_instr, 32'hFFFF_FFFC);
      chk("wrap_next_addr", imem_addr, 32'h0);

`ifdef IF_MISALIGN_CHECK_EN
      // 6: misaligned redirect traps, aligned redirect recovers
      redirect    = 1'b1;
      redirect_pc = 32'h102;
      step();
      redirect = 1'b0;
      chk("mis_exc", {31'b0, fetch_exc}, 32'd1);
      chk("mis_req", {31'b0, imem_req}, 32'd0);
      chk("mis_valid", {31'b0, ifid_valid}, 32'd0);
      step();
      chk("mis_exc_sticky", {31'b0, fetch_exc}, 32'd1);
      chk("mis_req_sticky", {31'b0, imem_req}, 32'd0);
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      chk("mis_clr_exc", {31'b0, fetch_exc}, 32'd0);
      chk("mis_clr_req", {31'b0, imem_req}, 32'd1);
      chk("mis_clr_addr", imem_addr, 32'h200);
      step();
      chk("mis_refetch", ifid_instr, 32'h200);
`else
      // Misaligned target is word-aligned by truncation and never flags
      redirect    = 1'b1;
      redirect_pc = 32'h102;
      step();
      redirect = 1'b0;
      chk("trunc_addr", imem_addr, 32'h100);
      chk("trunc_exc", {31'b0, fetch_exc}, 32'd0);
      chk("trunc_req", {31'b0, imem_req}, 32'd1);
      step();
      chk("trunc_instr", ifid_instr, 32'h100);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
